// File: rtl/hack_mem_pkg.sv
// Shared constants, region decode and screen-FIFO entry type for the Hack data memory.
// The region decode takes RAM_WORDS so that a smaller RAM leaves an unmapped hole below the screen.
package hack_mem_pkg;

  localparam logic [14:0] SCREEN_BASE  = 15'h4000;
  localparam int          SCREEN_WORDS = 8192;
  localparam logic [14:0] KBD_ADDR     = 15'h6000;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_NONE
  } region_t;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } scr_entry_t;

  function automatic region_t decode_region(input logic [14:0] addr, input int ram_words);
    region_t r;
    if ({17'd0, addr} < ram_words) begin
      r = REG_RAM;
    end else if (addr >= SCREEN_BASE && addr < KBD_ADDR) begin
      r = REG_SCREEN;
    end else if (addr == KBD_ADDR) begin
      r = REG_KBD;
    end else begin
      r = REG_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/hack_data_memory_if.sv
// CPU data bus, keyboard input and display-drain handshake of the Hack data memory.
// master = CPU / I/O side driving the memory, slave = the memory itself.
interface hack_data_memory_if;

  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [15:0] kbd_code;
  logic        kbd_strobe;
  logic        scr_valid;
  logic        scr_ready;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_overflow;

  modport master (
    output addressM, outM, writeM, kbd_code, kbd_strobe, scr_ready,
    input  inM, scr_valid, scr_addr, scr_data, scr_overflow
  );

  modport slave (
    input  addressM, outM, writeM, kbd_code, kbd_strobe, scr_ready,
    output inM, scr_valid, scr_addr, scr_data, scr_overflow
  );

endinterface

// File: rtl/hack_screen_fifo.sv
// Screen-write FIFO: DEPTH entries (power of two, >= 2), push/pop, sticky overflow, async reset.
// A push into a full FIFO is still accepted when a pop happens on the same edge.
module hack_screen_fifo
  import hack_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_push,
  input  scr_entry_t i_entry,
  input  logic       i_ready,
  output logic       o_valid,
  output scr_entry_t o_head,
  output logic       o_overflow
);

  localparam int             PW       = $clog2(DEPTH);
  localparam int             CW       = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);

  scr_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign o_valid    = (r_count != '0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_pop      = o_valid && i_ready;
  assign w_push_ok  = i_push && (!w_full || w_pop);
  assign o_head     = r_mem[r_rd_ptr];
  assign o_overflow = r_overflow;

  // Storage is not reset; only the pointers decide what is live.
  always_ff @(posedge clock) begin
    if (!reset && w_push_ok) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (i_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hack_data_memory.sv
// Hack CPU data-bus responder: RAM, keyboard register and a queued screen-write path.
// Optional HACK_SCREEN_SHADOW_EN builds an 8K-word shadow so SCREEN reads return written pixels.
module hack_data_memory
  import hack_mem_pkg::*;
#(
  parameter int RAM_WORDS  = 16384,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  hack_data_memory_if.slave   bus
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  region_t     w_region;
  logic        w_write;
  logic [15:0] w_screen_rd;
  scr_entry_t  w_push_entry;
  scr_entry_t  w_head;
  logic        w_push;

  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_kbd;

  assign w_region = decode_region(bus.addressM, RAM_WORDS);
  assign w_write  = bus.writeM && !reset;

  // Asynchronous read, so a same-edge write is seen as old data this cycle.
  always_ff @(posedge clock) begin
    if (w_write && w_region == REG_RAM) begin
      r_ram[bus.addressM[RAM_AW-1:0]] <= bus.outM;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_kbd <= 16'h0000;
    end else if (bus.kbd_strobe) begin
      r_kbd <= bus.kbd_code;
    end
  end

`ifdef HACK_SCREEN_SHADOW_EN
  logic [15:0] r_shadow [SCREEN_WORDS];

  // Mirrors every screen write, including ones the FIFO drops.
  always_ff @(posedge clock) begin
    if (w_write && w_region == REG_SCREEN) begin
      r_shadow[bus.addressM[12:0]] <= bus.outM;
    end
  end

  assign w_screen_rd = r_shadow[bus.addressM[12:0]];
`else
  assign w_screen_rd = 16'h0000;
`endif

  always_comb begin
    bus.inM = 16'h0000;
    case (w_region)
      REG_RAM:    bus.inM = r_ram[bus.addressM[RAM_AW-1:0]];
      REG_SCREEN: bus.inM = w_screen_rd;
      REG_KBD:    bus.inM = r_kbd;
      default:    bus.inM = 16'h0000;
    endcase
  end

  // Screen occupies 0x4000-0x5FFF, so the low 13 address bits are the word offset.
  assign w_push_entry.addr = bus.addressM[12:0];
  assign w_push_entry.data = bus.outM;
  assign w_push            = bus.writeM && (w_region == REG_SCREEN);

  hack_screen_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_push),
    .i_entry    (w_push_entry),
    .i_ready    (bus.scr_ready),
    .o_valid    (bus.scr_valid),
    .o_head     (w_head),
    .o_overflow (bus.scr_overflow)
  );

  assign bus.scr_addr = w_head.addr;
  assign bus.scr_data = w_head.data;

endmodule

// File: tb/tb_hack_data_memory.sv
// Bench for hack_data_memory: vector table for RAM/keyboard/unmapped reads plus screen-FIFO
// sequences checked against a scoreboard of expected drained entries.
module tb_hack_data_memory;
  import hack_mem_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   n_pops;

  scr_entry_t sb[$];

  hack_data_memory_if bus();

  hack_data_memory #(
    .RAM_WORDS  (16384),
    .FIFO_DEPTH (4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    logic        we;
    logic [15:0] kcode;
    logic        kstb;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic scr_entry_t mk(input logic [12:0] a, input logic [15:0] d);
    scr_entry_t e;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake pop is compared with the oldest expected entry.
  always @(negedge clk) begin
    scr_entry_t e;
    if (!rst && bus.scr_valid && bus.scr_ready) begin
      n_pops++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL scr_pop: got unexpected entry %h/%h, expected none", bus.scr_addr, bus.scr_data);
      end else begin
        e = sb.pop_front();
        chk("scr_addr", {3'b000, bus.scr_addr}, {3'b000, e.addr});
        chk("scr_data", bus.scr_data, e.data);
        $display("pop addr=%h data=%h", bus.scr_addr, bus.scr_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_pops   = 0;
    rst            = 1'b1;
    bus.addressM   = 15'h6000;
    bus.outM       = 16'h0000;
    bus.writeM     = 1'b0;
    bus.kbd_code   = 16'h0000;
    bus.kbd_strobe = 1'b0;
    bus.scr_ready  = 1'b0;

    //        addr      data      we    kcode     kstb  chk   exp
    vecs[0]  = '{15'h0005, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{15'h0005, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234};
    vecs[2]  = '{15'h0005, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h1234};
    vecs[3]  = '{15'h0005, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
    vecs[4]  = '{15'h7000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
    vecs[5]  = '{15'h7000, 16'h5555, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000};
    vecs[6]  = '{15'h7000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
    vecs[7]  = '{15'h3FFF, 16'h0F0F, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{15'h3FFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0F0F};
    vecs[9]  = '{15'h6000, 16'h0000, 1'b0, 16'h0041, 1'b1, 1'b1, 16'h0000};
    vecs[10] = '{15'h6000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0041};
    vecs[11] = '{15'h6000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0041};
    vecs[12] = '{15'h6000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0041};
    vecs[13] = '{15'h6000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0041};
    vecs[14] = '{15'h6000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
    vecs[15] = '{15'h6001, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};

    // Reset state
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_scr_valid", {15'd0, bus.scr_valid}, 16'h0000);
    chk("rst_overflow", {15'd0, bus.scr_overflow}, 16'h0000);
    chk("rst_kbd", bus.inM, 16'h0000);
    cyc();
    rst = 1'b0;

    // Vector table: inM sampled before the committing edge
    for (int i = 0; i < 16; i++) begin
      bus.addressM   = vecs[i].addr;
      bus.outM       = vecs[i].data;
      bus.writeM     = vecs[i].we;
      bus.kbd_code   = vecs[i].kcode;
      bus.kbd_strobe = vecs[i].kstb;
      @(negedge clk);
      $display("vec %0d addr=%h we=%b data=%h inM=%h", i, vecs[i].addr, vecs[i].we, vecs[i].data, bus.inM);
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d_inM", i), bus.inM, vecs[i].exp);
      end
      cyc();
    end
    bus.writeM     = 1'b0;
    bus.kbd_strobe = 1'b0;

    // Single screen write, then drained
    bus.addressM = 15'h4001;
    bus.outM     = 16'hAAAA;
    bus.writeM   = 1'b1;
    sb.push_back(mk(13'h0001, 16'hAAAA));
    cyc();
    bus.writeM = 1'b0;
    @(negedge clk);
    chk("single_valid", {15'd0, bus.scr_valid}, 16'h0001);
    chk("single_addr", {3'b000, bus.scr_addr}, 16'h0001);
    chk("single_data", bus.scr_data, 16'hAAAA);
    cyc();
    bus.scr_ready = 1'b1;
    cyc();
    bus.scr_ready = 1'b0;
    @(negedge clk);
    chk("single_drained", {15'd0, bus.scr_valid}, 16'h0000);

    // Fill to 4 entries
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.addressM = 15'h4000 + 15'(i);
      bus.outM     = 16'h1000 + 16'(i);
      bus.writeM   = 1'b1;
      sb.push_back(mk(13'(i), 16'h1000 + 16'(i)));
    end
    cyc();
    bus.writeM = 1'b0;
    @(negedge clk);
    chk("full_overflow", {15'd0, bus.scr_overflow}, 16'h0000);
    chk("full_valid", {15'd0, bus.scr_valid}, 16'h0001);

    // Full FIFO with simultaneous push and pop: accepted, no overflow
    cyc();
    bus.addressM  = 15'h4010;
    bus.outM      = 16'h2222;
    bus.writeM    = 1'b1;
    bus.scr_ready = 1'b1;
    sb.push_back(mk(13'h0010, 16'h2222));
    cyc();
    bus.writeM    = 1'b0;
    bus.scr_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_overflow", {15'd0, bus.scr_overflow}, 16'h0000);
    chk("pushpop_head", {3'b000, bus.scr_addr}, 16'h0001);

    // Still full, so this write is dropped
    cyc();
    bus.addressM = 15'h4011;
    bus.outM     = 16'h3333;
    bus.writeM   = 1'b1;
    cyc();
    bus.writeM = 1'b0;
    @(negedge clk);
    chk("drop_overflow", {15'd0, bus.scr_overflow}, 16'h0001);

    // Drain: exactly four entries in order, overflow stays set
    cyc();
    n_pops = 0;
    bus.scr_ready = 1'b1;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (!bus.scr_valid) break;
      end
      if (k == 20) begin
        n_checks++;
        $display("FAIL drain_timeout: scr_valid still 1 after 20 cycles, expected 0");
      end
    end
    bus.scr_ready = 1'b0;
    chk("drain_count", 16'(n_pops), 16'd4);
    chk("drain_sb_empty", 16'(sb.size()), 16'd0);
    chk("sticky_overflow", {15'd0, bus.scr_overflow}, 16'h0001);

    // Reset mid-drain with three entries queued
    cyc();
    bus.addressM = 15'd100;
    bus.outM     = 16'hCAFE;
    bus.writeM   = 1'b1;
    bus.kbd_code   = 16'h0041;
    bus.kbd_strobe = 1'b1;
    cyc();
    bus.kbd_strobe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.addressM = 15'h4100 + 15'(i);
      bus.outM     = 16'h7000 + 16'(i);
      bus.writeM   = 1'b1;
      sb.push_back(mk(13'h0100 + 13'(i), 16'h7000 + 16'(i)));
      cyc();
    end
    bus.writeM = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {15'd0, bus.scr_valid}, 16'h0001);
    cyc();
    bus.scr_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("async_rst_valid", {15'd0, bus.scr_valid}, 16'h0000);
    chk("async_rst_overflow", {15'd0, bus.scr_overflow}, 16'h0000);
    bus.addressM = 15'd100;
    #1;
    chk("rst_ram_kept", bus.inM, 16'hCAFE);
    bus.addressM = 15'h6000;
    #1;
    chk("rst_kbd_clear", bus.inM, 16'h0000);

    // Writes while reset is high are ignored
    bus.addressM = 15'd100;
    bus.outM     = 16'h0000;
    bus.writeM   = 1'b1;
    cyc();
    bus.addressM = 15'h4000;
    bus.outM     = 16'h9999;
    cyc();
    bus.writeM    = 1'b0;
    bus.scr_ready = 1'b0;
    rst           = 1'b0;
    bus.addressM  = 15'd100;
    @(negedge clk);
    chk("rst_write_ignored", bus.inM, 16'hCAFE);
    chk("rst_push_ignored", {15'd0, bus.scr_valid}, 16'h0000);

    // Screen read at 0x5FFF
    cyc();
    bus.addressM = 15'h5FFF;
    bus.outM     = 16'h00FF;
    bus.writeM   = 1'b1;
    sb.push_back(mk(13'h1FFF, 16'h00FF));
    cyc();
    bus.writeM = 1'b0;
    @(negedge clk);
`ifdef HACK_SCREEN_SHADOW_EN
    chk("screen_read", bus.inM, 16'h00FF);
`else
    chk("screen_read", bus.inM, 16'h0000);
`endif
    cyc();
    bus.scr_ready = 1'b1;
    cyc();
    bus.scr_ready = 1'b0;
    @(negedge clk);
    chk("final_valid", {15'd0, bus.scr_valid}, 16'h0000);
    chk("final_sb_empty", 16'(sb.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Responder side of the Hack CPU data bus: decodes addressM, returns inM, and commits outM on writeM.
- Maps RAM (0x0000–0x3FFF), screen (0x4000–0x5FFF) and keyboard (0x6000).
- Screen writes are queued in a small FIFO and drained to a display controller over a valid/ready handshake.
- Sits between the CPU and the top-level I/O.

Parameters:
- RAM_WORDS, 16384, number of 16-bit RAM words; must be at most 16384.
- FIFO_DEPTH, 4, number of screen-write FIFO entries; must be a power of two and at least 2.

Ports:
- clock  input  1  system clock; every register updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- addressM  input  15  CPU data address.
- outM  input  16  CPU write data.
- writeM  input  1  CPU write strobe; the write commits on the next rising edge.
- inM  output  16  read data for addressM; combinational, zero-latency read.
- kbd_code  input  16  key code from the keyboard front end; 0 means no key.
- kbd_strobe  input  1  one-cycle pulse; kbd_code is captured when this is high.
- scr_valid  output  1  FIFO head entry is valid.
- scr_ready  input  1  display controller accepts the head entry.
- scr_addr  output  13  screen word offset (addressM − 0x4000) of the head entry.
- scr_data  output  16  pixel word of the head entry.
- scr_overflow  output  1  sticky flag: a screen write was dropped because the FIFO was full.

Behaviour:
- Address decode:
  - RAM: addressM < RAM_WORDS.
  - SCREEN: 0x4000–0x5FFF.
  - KBD: exactly 0x6000.
  - Everything else is unmapped: reads return 0, writes are ignored.
  - If RAM_WORDS < 16384, the hole between RAM_WORDS and 0x3FFF is unmapped.
- RAM:
  - Register array with asynchronous read: inM = ram[addressM] in the same cycle.
  - Synchronous write when writeM is high.
  - Contents are not cleared by reset; the bench must write before it reads.
- Read-during-write: inM shows the old word. The new word is visible from the cycle after the edge.
- KBD:
  - kbd_reg loads kbd_code on any edge where kbd_strobe is high.
  - inM = kbd_reg when addressing 0x6000.
  - CPU writes to 0x6000 are ignored.
- SCREEN write:
  - writeM at a SCREEN address pushes {addressM[12:0], outM} into the FIFO at the edge.
  - Without the optional feature, SCREEN reads return 0.
- FIFO:
  - Pointers and count are registered.
  - scr_valid = (count != 0). scr_addr and scr_data come from the head slot.
  - Pop when scr_valid and scr_ready are both high.
  - Push and pop in the same cycle:
    - count is unchanged and both pointers advance.
    - This holds when full too: if the pop happens, the push is accepted.
  - Push when full and no pop: the entry is dropped and scr_overflow is set.
  - scr_overflow is sticky; only reset clears it.
  - Pointers wrap modulo FIFO_DEPTH.
  - When the FIFO is empty, scr_ready is ignored. scr_addr and scr_data are don't-care; the bench must not check them.
- Reset (asynchronous, at any time):
  - FIFO pointers and count go to 0, so scr_valid = 0.
  - kbd_reg = 0 and scr_overflow = 0.
  - Queued entries are discarded, even mid-drain.
  - RAM and any shadow memory keep their contents.
  - writeM, kbd_strobe and scr_ready are ignored while reset is high.
- No CPU stall path exists: the CPU never waits. Loss of screen writes is reported only through scr_overflow.

Optional Feature:
- Macro HACK_SCREEN_SHADOW_EN.
- Defined:
  - An 8192-word shadow array mirrors every SCREEN write, including writes the FIFO dropped.
  - SCREEN reads return the shadow word with the same asynchronous read and old-data-on-write rule as RAM.
  - Reset does not clear the shadow array.
- Undefined:
  - No shadow storage is built.
  - SCREEN reads return 0x0000.

Decomposition:
- Package hack_mem_pkg holds:
  - constants SCREEN_BASE = 15'h4000, SCREEN_WORDS = 8192, KBD_ADDR = 15'h6000;
  - the region enum {REG_RAM, REG_SCREEN, REG_KBD, REG_NONE};
  - the packed struct scr_entry_t {logic [12:0] addr; logic [15:0] data;}.
- One sub-module: hack_screen_fifo, a parameterized FIFO of scr_entry_t with push/pop, full/empty, overflow flag and async active-high reset.
- Decode and the RAM / shadow arrays stay in the top module.

Test Plan:
- RAM: write 0x1234 to address 5 → inM = 0x1234 at address 5 on the next cycle. Read address 0x7000 → inM = 0x0000.
- Keyboard: kbd_strobe with code 0x0041 → inM = 0x0041 at 0x6000. A CPU write of 0xFFFF to 0x6000 → still 0x0041. Strobe with code 0 → 0x0000.
- Screen queue, scr_ready held low: write 0xAAAA to 0x4001 → scr_valid = 1, scr_addr = 1, scr_data = 0xAAAA. Raise scr_ready → entry popped and scr_valid = 0 (single entry).
- Overflow, FIFO_DEPTH = 4, scr_ready low: 5 screen writes → 4 entries drained in order and scr_overflow = 1 until reset. Full FIFO with simultaneous push and pop → count stays 4 and no overflow.
- Reset mid-drain with 3 entries queued → scr_valid = 0 immediately (asynchronous), scr_overflow = 0, RAM word written earlier still reads back.
- Optional feature: write 0x00FF to 0x5FFF → read returns 0x00FF with HACK_SCREEN_SHADOW_EN defined, 0x0000 without it.
